// File: rtl/prf_free_list.sv
// prf_free_list: physical-tag free list for rename; grants free PRF tags, reclaims superseded tags at commit,
// rebuilds from the committed bitmap on flush.
// Ports: alloc_req/alloc_gnt/alloc_tag (zero-latency grant), commit_valid/commit_new_tag/commit_old_tag (commit),
// flush/busy (rebuild control), free_count (FIFO occupancy), err_dbl_free (sticky, only with FREE_LIST_CHECK_EN).
module prf_free_list #(
  parameter int NUM_PRF = 16,
  parameter int TAG_W   = 4,
  parameter int NUM_ARF = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             commit_valid,
  input  logic [TAG_W-1:0] commit_new_tag,
  input  logic [TAG_W-1:0] commit_old_tag,
  input  logic             flush,
  output logic             busy,
  output logic [TAG_W:0]   free_count,
  output logic             err_dbl_free
);
  typedef enum logic {RUN, REBUILD} state_e;
  state_e               state_q;
  logic [TAG_W-1:0]     fifo_q [NUM_PRF];
  logic [TAG_W-1:0]     head_q, tail_q, scan_q, push_tag;
  logic [TAG_W:0]       count_q;
  logic [NUM_PRF-1:0]   committed_q, committed_d;
  logic                 run, push_req, push_ok, dbl;
`ifdef FREE_LIST_CHECK_EN
  logic [NUM_PRF-1:0]   free_q, free_d;
  logic                 err_q;
`endif
  always_comb begin
    run = state_q == RUN;
    alloc_gnt = !rst && run && !flush && alloc_req && count_q != '0;
    alloc_tag = fifo_q[head_q];
    push_tag = run ? commit_old_tag : scan_q;
    // tag 0 belongs to r0 forever, so it is never pushed from either source
    push_req = run ? commit_valid && commit_old_tag != '0 : !committed_q[scan_q] && scan_q != '0;
`ifdef FREE_LIST_CHECK_EN
    dbl = run && push_req && free_q[push_tag];
    err_dbl_free = err_q;
`else
    dbl = 1'b0;
    err_dbl_free = 1'b0;
`endif
    push_ok = push_req && !flush && !dbl && count_q != (TAG_W+1)'(NUM_PRF);
    committed_d = committed_q;
    if (run && commit_valid) begin
      if (commit_old_tag != '0) committed_d[commit_old_tag] = 1'b0;
      committed_d[commit_new_tag] = 1'b1;
    end
    busy = !run;
    free_count = rst ? (TAG_W+1)'(NUM_PRF - NUM_ARF) : count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      head_q <= '0;
      tail_q <= TAG_W'(NUM_PRF - NUM_ARF);
      count_q <= (TAG_W+1)'(NUM_PRF - NUM_ARF);
      scan_q <= '0;
      for (int i = 0; i < NUM_PRF; i++) begin
        fifo_q[i] <= i < NUM_PRF - NUM_ARF ? TAG_W'(NUM_ARF + i) : '0;
        committed_q[i] <= i < NUM_ARF;
      end
    end else begin
      committed_q <= committed_d;
      if (flush) begin
        state_q <= REBUILD;
        head_q <= '0;
        tail_q <= '0;
        count_q <= '0;
        scan_q <= '0;
      end else begin
        if (alloc_gnt) head_q <= head_q + 1'b1;
        if (push_ok) begin
          fifo_q[tail_q] <= push_tag;
          tail_q <= tail_q + 1'b1;
        end
        count_q <= count_q + (TAG_W+1)'(push_ok) - (TAG_W+1)'(alloc_gnt);
        if (!run) begin
          scan_q <= scan_q + 1'b1;
          if (scan_q == TAG_W'(NUM_PRF - 1)) state_q <= RUN;
        end
      end
    end
  end
`ifdef FREE_LIST_CHECK_EN
  always_comb begin
    free_d = free_q;
    if (alloc_gnt) free_d[alloc_tag] = 1'b0;
    if (push_ok) free_d[push_tag] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PRF; i++) free_q[i] <= i >= NUM_ARF;
      err_q <= 1'b0;
    end else begin
      free_q <= flush ? '0 : free_d;
      err_q <= err_q | (dbl && !flush);
    end
  end
`endif
endmodule

// File: doc/prf_free_list.md
Name: prf_free_list

Overview:
- Physical-tag allocator for the rename stage; owns the set of free PRF tags behind the ARF rename table.
- Grants a free tag to a renaming instruction and reclaims superseded tags at commit.
- Tracks the committed mapping in a bitmap. On flush it rebuilds the free list from that bitmap, so speculative allocations are recovered.
- Sits between decode/rename (allocation) and the commit logic that writes ARF_tag.

Parameters:
- NUM_PRF, 16, number of physical tags; power of two.
- TAG_W, 4, tag width; equals log2(NUM_PRF).
- NUM_ARF, 8, number of architectural registers; tags 0..NUM_ARF-1 are committed at reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- alloc_req  in  1  rename needs a tag; dest reg is nonzero
- alloc_gnt  out  1  tag granted this cycle
- alloc_tag  out  TAG_W  granted tag; valid when alloc_gnt=1
- commit_valid  in  1  commit of a renamed dest this cycle
- commit_new_tag  in  TAG_W  tag becoming committed
- commit_old_tag  in  TAG_W  previously committed tag; freed
- flush  in  1  squash speculative state and rebuild
- busy  out  1  rebuild in progress
- free_count  out  TAG_W+1  entries currently in the free FIFO
- err_dbl_free  out  1  sticky double-free error (see Optional Feature)

Behaviour:
- Interface: one clock domain, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Storage:
  - Circular FIFO of NUM_PRF entries, with head, tail and a count of width TAG_W+1.
  - committed bitmap, NUM_PRF bits.
- Reset state:
  - FIFO entry i = NUM_ARF+i for i < NUM_PRF-NUM_ARF.
  - head=0, tail=NUM_PRF-NUM_ARF, count=NUM_PRF-NUM_ARF (8).
  - committed[0..NUM_ARF-1]=1, all other bits 0.
  - State RUN, busy=0, err_dbl_free=0.
  - With rst high: alloc_gnt=0, free_count=8.
- States: RUN and REBUILD.
- RUN, allocation:
  - alloc_tag = FIFO[head] (combinational read).
  - alloc_gnt = alloc_req & (count!=0), zero latency. On the edge, head advances and count decrements.
- RUN, commit:
  - commit_valid sets committed[commit_new_tag] and clears committed[commit_old_tag].
  - It also pushes commit_old_tag at tail; tail advances and count increments.
  - If commit_old_tag==0, the push is suppressed. Tag 0 is permanently bound to r0 and is never freed.
- Simultaneous grant and push: count is unchanged, and both pointers move.
- Empty FIFO plus a push in the same cycle: alloc_gnt=0. There is no bypass; the pushed tag is grantable the next cycle.
- Full FIFO (count==NUM_PRF): cannot occur legally. A push at full is dropped.
- Pointers wrap modulo NUM_PRF.
- Flush:
  - Highest priority below rst. A commit_valid in the same cycle updates committed first; it is architecturally older. Its push is discarded.
  - On the edge: head=tail=0, count=0, scan index=0, state goes to REBUILD.
- REBUILD:
  - busy=1 and alloc_gnt=0. commit_valid must be 0 (the pipeline is drained); it is ignored.
  - Each cycle, scan index i goes from 0 to NUM_PRF-1. If committed[i]==0, tag i is pushed.
  - At i==NUM_PRF-1, next state is RUN. REBUILD lasts exactly NUM_PRF cycles.
  - busy falls the cycle after the last scan; free_count then equals NUM_PRF - popcount(committed).
- Flush during REBUILD restarts the scan at 0 with an empty FIFO.
- rst at any time returns to the reset state on the next edge.

Optional Feature:
- Macro: FREE_LIST_CHECK_EN.
- Defined:
  - Adds a free bitmap: set on push, cleared on grant. It is rebuilt as ~committed during REBUILD; bit 0 is never set.
  - A commit push whose tag already has its free bit set is dropped.
  - err_dbl_free is set and stays 1 until rst.
- Not defined: no free bitmap, no check, err_dbl_free tied to 0.

Test Plan:
- Reset, then hold alloc_req for 9 cycles -> grants of tags 8,9,...,15 on cycles 1-8. Cycle 9 has alloc_gnt=0 and free_count=0.
- With the list empty, commit_valid with new=8 and old=3 plus alloc_req in the same cycle -> alloc_gnt=0 that cycle. Next cycle alloc_gnt=1 with alloc_tag=3; free_count goes 0→1→0.
- commit_valid with old=0 -> free_count unchanged, tag 0 never granted.
- After 8 grants and a commit (new=8, old=1), assert flush:
  - busy is high for 16 cycles, then free_count=8.
  - Subsequent grants are in order 1,9,10,...,15.
- Flush asserted again on scan cycle 5 of REBUILD -> REBUILD restarts and lasts 16 more cycles; the final free set is the same.
- With FREE_LIST_CHECK_EN defined: reset, then commit old=12 (12 is already free) -> err_dbl_free=1 next cycle and free_count stays 8. Without the macro, err_dbl_free stays 0.
